// File: rtl/dram_req_sched.sv
// DRAM cycle scheduler: arbitrates refresh, CPU and video requests onto one DRAM sequencer.
// Grant statistics are built only when DRAM_REQ_SCHED_STATS_EN is defined.
module dram_req_sched #(
   parameter int unsigned RFSH_DIV      = 436,
   parameter int unsigned RFSH_MAX_PEND = 4,
   parameter int unsigned CPU_MIN_SLOT  = 4
) (
   input  logic        fclk,
   input  logic        rst_n,
   input  logic        video_req,
   input  logic [20:0] video_addr,
   input  logic        cpu_req,
   input  logic        cpu_rnw,
   input  logic [20:0] cpu_addr,
   input  logic [15:0] cpu_wrdata,
   input  logic [1:0]  cpu_bsel,
   output logic        video_grant,
   output logic        cpu_grant,
   output logic        dram_go,
   output logic        dram_rfsh,
   output logic        dram_rnw,
   output logic [20:0] dram_addr,
   output logic [15:0] dram_wrdata,
   output logic [1:0]  dram_bsel,
   input  logic        dram_cyc_end,
   output logic [2:0]  rfsh_pend,
   output logic        rfsh_ovf,
   output logic [15:0] stat_video,
   output logic [15:0] stat_cpu,
   output logic [15:0] stat_rfsh,
   input  logic        stat_clr
);
   localparam int unsigned DIV_W  = (RFSH_DIV > 1) ? $clog2(RFSH_DIV) : 1;
   localparam int unsigned STRK_W = (CPU_MIN_SLOT > 0) ? $clog2(CPU_MIN_SLOT + 1) : 1;
   localparam logic [DIV_W-1:0]  DIV_LOAD = DIV_W'(RFSH_DIV - 1);
   localparam logic [2:0]        PEND_MAX = 3'(RFSH_MAX_PEND);
   localparam logic [STRK_W-1:0] STRK_MAX = STRK_W'(CPU_MIN_SLOT);

   typedef enum logic {IDLE, WAIT_END} state_t;

   state_t            state;
   logic [DIV_W-1:0]  div_cnt;
   logic [STRK_W-1:0] streak;
   logic              tick;
   logic              pick_rfsh, pick_cpu, pick_video;

   assign tick = (div_cnt == '0);

   always_comb begin
      pick_rfsh  = 1'b0;
      pick_cpu   = 1'b0;
      pick_video = 1'b0;
      if (state == IDLE) begin
         if (rfsh_pend == PEND_MAX)            pick_rfsh  = 1'b1;
         else if (cpu_req && streak == STRK_MAX) pick_cpu = 1'b1;
         else if (video_req)                   pick_video = 1'b1;
         else if (cpu_req)                     pick_cpu   = 1'b1;
         else if (rfsh_pend != '0)             pick_rfsh  = 1'b1;
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         dram_go     <= 1'b0;
         video_grant <= 1'b0;
         cpu_grant   <= 1'b0;
         dram_rfsh   <= 1'b0;
         dram_rnw    <= 1'b0;
         dram_addr   <= '0;
         dram_wrdata <= '0;
         dram_bsel   <= '0;
         streak      <= '0;
      end else begin
         dram_go     <= 1'b0;
         video_grant <= 1'b0;
         cpu_grant   <= 1'b0;
         case (state)
            IDLE: begin
               if (pick_rfsh) begin
                  dram_go   <= 1'b1;
                  dram_rfsh <= 1'b1;
                  dram_rnw  <= 1'b1;
                  state     <= WAIT_END;
               end else if (pick_cpu) begin
                  dram_go     <= 1'b1;
                  cpu_grant   <= 1'b1;
                  dram_rfsh   <= 1'b0;
                  dram_rnw    <= cpu_rnw;
                  dram_addr   <= cpu_addr;
                  dram_wrdata <= cpu_wrdata;
                  dram_bsel   <= cpu_bsel;
                  state       <= WAIT_END;
               end else if (pick_video) begin
                  dram_go     <= 1'b1;
                  video_grant <= 1'b1;
                  dram_rfsh   <= 1'b0;
                  dram_rnw    <= 1'b1;
                  dram_addr   <= video_addr;
                  dram_bsel   <= 2'b11;
                  state       <= WAIT_END;
               end
            end
            WAIT_END: if (dram_cyc_end) state <= IDLE;
            default:  state <= IDLE;
         endcase
         // Streak only matters while the CPU is waiting, so an idle CPU resets it.
         if ((state == IDLE && !cpu_req) || pick_cpu)
            streak <= '0;
         else if (pick_video && streak != STRK_MAX)
            streak <= streak + 1'b1;
      end
   end

   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         div_cnt   <= DIV_LOAD;
         rfsh_pend <= '0;
         rfsh_ovf  <= 1'b0;
      end else begin
         div_cnt <= tick ? DIV_LOAD : div_cnt - 1'b1;
         case ({tick, pick_rfsh})
            2'b10: begin
               if (rfsh_pend == PEND_MAX) rfsh_ovf <= 1'b1;
               else                       rfsh_pend <= rfsh_pend + 1'b1;
            end
            2'b01:   rfsh_pend <= rfsh_pend - 1'b1;
            default: rfsh_pend <= rfsh_pend;
         endcase
      end
   end

`ifdef DRAM_REQ_SCHED_STATS_EN
   always_ff @(posedge fclk or negedge rst_n) begin
      if (!rst_n) begin
         stat_video <= '0;
         stat_cpu   <= '0;
         stat_rfsh  <= '0;
      end else if (stat_clr) begin
         stat_video <= '0;
         stat_cpu   <= '0;
         stat_rfsh  <= '0;
      end else begin
         if (pick_video && stat_video != '1) stat_video <= stat_video + 1'b1;
         if (pick_cpu   && stat_cpu   != '1) stat_cpu   <= stat_cpu + 1'b1;
         if (pick_rfsh  && stat_rfsh  != '1) stat_rfsh  <= stat_rfsh + 1'b1;
      end
   end
`else
   logic unused_stat_clr;
   assign unused_stat_clr = stat_clr;
   assign stat_video = '0;
   assign stat_cpu   = '0;
   assign stat_rfsh  = '0;
`endif

endmodule

// File: tb/tb_dram_req_sched.sv
// Directed bench for dram_req_sched: dut_a (default divider, auto-ending sequencer)
// and dut_b (RFSH_DIV=8, hand-driven cycle end) for refresh timing cases.
module tb_dram_req_sched;
   logic        fclk = 1'b0;
   always #5 fclk = ~fclk;

   int checks   = 0;
   int failures = 0;

   // dut_a
   logic        rst_a, video_req_a, cpu_req, cpu_rnw, stat_clr, cyc_end_a;
   logic [20:0] video_addr_a, cpu_addr;
   logic [15:0] cpu_wrdata;
   logic [1:0]  cpu_bsel;
   logic        video_grant_a, cpu_grant_a, go_a, rfsh_a, rnw_a, ovf_a;
   logic [20:0] addr_a;
   logic [15:0] wrdata_a, stv_a, stc_a, str_a;
   logic [1:0]  bsel_a;
   logic [2:0]  pend_a;

   // dut_b
   logic        rst_b, video_req_b, cyc_end_b;
   logic [20:0] video_addr_b = 21'h0ABCD;
   logic        video_grant_b, cpu_grant_b, go_b, rfsh_b, rnw_b, ovf_b;
   logic [20:0] addr_b;
   logic [15:0] wrdata_b, stv_b, stc_b, str_b;
   logic [1:0]  bsel_b;
   logic [2:0]  pend_b;

   dram_req_sched dut_a (
      .fclk(fclk), .rst_n(rst_a), .video_req(video_req_a), .video_addr(video_addr_a),
      .cpu_req(cpu_req), .cpu_rnw(cpu_rnw), .cpu_addr(cpu_addr), .cpu_wrdata(cpu_wrdata),
      .cpu_bsel(cpu_bsel), .video_grant(video_grant_a), .cpu_grant(cpu_grant_a),
      .dram_go(go_a), .dram_rfsh(rfsh_a), .dram_rnw(rnw_a), .dram_addr(addr_a),
      .dram_wrdata(wrdata_a), .dram_bsel(bsel_a), .dram_cyc_end(cyc_end_a),
      .rfsh_pend(pend_a), .rfsh_ovf(ovf_a), .stat_video(stv_a), .stat_cpu(stc_a),
      .stat_rfsh(str_a), .stat_clr(stat_clr)
   );

   dram_req_sched #(.RFSH_DIV(8)) dut_b (
      .fclk(fclk), .rst_n(rst_b), .video_req(video_req_b), .video_addr(video_addr_b),
      .cpu_req(1'b0), .cpu_rnw(1'b1), .cpu_addr(21'h0), .cpu_wrdata(16'h0),
      .cpu_bsel(2'b00), .video_grant(video_grant_b), .cpu_grant(cpu_grant_b),
      .dram_go(go_b), .dram_rfsh(rfsh_b), .dram_rnw(rnw_b), .dram_addr(addr_b),
      .dram_wrdata(wrdata_b), .dram_bsel(bsel_b), .dram_cyc_end(cyc_end_b),
      .rfsh_pend(pend_b), .rfsh_ovf(ovf_b), .stat_video(stv_b), .stat_cpu(stc_b),
      .stat_rfsh(str_b), .stat_clr(1'b0)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic reset_a();
      rst_a = 1'b0;
      repeat (2) @(posedge fclk);
      #1 rst_a = 1'b1;
   endtask

   task automatic reset_b();
      rst_b = 1'b0;
      repeat (2) @(posedge fclk);
      #1 rst_b = 1'b1;
   endtask

   task automatic wait_go_a(input int max_cyc, output bit seen);
      seen = 1'b0;
      for (int c = 0; c < max_cyc && !seen; c++) begin
         @(posedge fclk); #1;
         if (go_a) seen = 1'b1;
      end
   endtask

   task automatic grant_a(input bit use_cpu);
      bit seen;
      if (use_cpu) cpu_req = 1'b1; else video_req_a = 1'b1;
      wait_go_a(20, seen);
      cpu_req = 1'b0;
      video_req_a = 1'b0;
      repeat (5) @(posedge fclk);
      #1;
   endtask

   // Sequencer model for dut_a: end pulse sampled on the third edge after dram_go.
   initial begin
      cyc_end_a = 1'b0;
      forever begin
         @(posedge fclk); #1;
         if (go_a) begin
            repeat (2) @(posedge fclk);
            #1 cyc_end_a = 1'b1;
            @(posedge fclk);
            #1 cyc_end_a = 1'b0;
         end
      end
   end

   initial begin
      bit seen;
      int got_seq[10];
      int exp_seq[10] = '{1, 1, 1, 1, 2, 1, 1, 1, 1, 2};
      int ng, gos, first, second;
      logic [15:0] exp_v, exp_c;

      rst_a = 1'b0; rst_b = 1'b0;
      video_req_a = 1'b0; video_addr_a = '0; cpu_req = 1'b0; cpu_rnw = 1'b1;
      cpu_addr = '0; cpu_wrdata = '0; cpu_bsel = '0; stat_clr = 1'b0;
      video_req_b = 1'b0; cyc_end_b = 1'b0;
      repeat (2) @(posedge fclk);
      #1;
      check("rst_a_ctrl", {go_a, video_grant_a, cpu_grant_a, rfsh_a, rnw_a, bsel_a}, 0);
      check("rst_a_pend", {ovf_a, pend_a}, 0);
      check("rst_b_ctrl", {go_b, rfsh_b, rnw_b, pend_b, ovf_b}, 0);
      rst_a = 1'b1;

      // CPU write issue, then reset two cycles into the access
      cpu_req = 1'b1; cpu_rnw = 1'b0; cpu_addr = 21'h12345;
      cpu_wrdata = 16'hBEEF; cpu_bsel = 2'b01;
      wait_go_a(20, seen);
      check("cpu_go_seen", seen, 1);
      check("cpu_grant", {cpu_grant_a, video_grant_a, rfsh_a, rnw_a}, 4'b1000);
      check("cpu_addr", addr_a, 21'h12345);
      check("cpu_wrdata", wrdata_a, 16'hBEEF);
      check("cpu_bsel", bsel_a, 2'b01);
      cpu_req = 1'b0;
      repeat (2) @(posedge fclk);
      #1 rst_a = 1'b0;
      #1;
      check("midrst_ctrl", {go_a, video_grant_a, cpu_grant_a, rfsh_a, rnw_a, bsel_a}, 0);
      check("midrst_data", {addr_a, wrdata_a}, 0);
      @(posedge fclk);
      #1 rst_a = 1'b1;
      gos = 0;
      for (int c = 0; c < 6; c++) begin
         @(posedge fclk); #1;
         if (go_a) gos++;
      end
      check("no_issue_after_rst", gos, 0);
      video_req_a = 1'b1; video_addr_a = 21'h1F00A;
      wait_go_a(20, seen);
      check("vid_go_seen", seen, 1);
      check("vid_fields", {video_grant_a, cpu_grant_a, rnw_a, bsel_a}, 5'b10111);
      check("vid_addr", addr_a, 21'h1F00A);
      video_req_a = 1'b0;
      repeat (6) @(posedge fclk);

      // Priority: both requesters held
      reset_a();
      video_req_a = 1'b1; cpu_req = 1'b1; cpu_rnw = 1'b1;
      ng = 0;
      for (int i = 0; i < 10; i++) got_seq[i] = 0;
      for (int c = 0; c < 100 && ng < 10; c++) begin
         @(posedge fclk); #1;
         if (video_grant_a) begin got_seq[ng] = 1; ng++; end
         else if (cpu_grant_a) begin got_seq[ng] = 2; ng++; end
      end
      for (int i = 0; i < 10; i++) check($sformatf("prio_%0d", i), got_seq[i], exp_seq[i]);
      video_req_a = 1'b0; cpu_req = 1'b0;
      repeat (6) @(posedge fclk);

      // Statistics: 3 CPU grants, 2 video grants, then clear
      reset_a();
      grant_a(1'b1); grant_a(1'b0); grant_a(1'b1); grant_a(1'b0); grant_a(1'b1);
`ifdef DRAM_REQ_SCHED_STATS_EN
      exp_c = 16'd3; exp_v = 16'd2;
`else
      exp_c = 16'd0; exp_v = 16'd0;
`endif
      check("stat_cpu", stc_a, exp_c);
      check("stat_video", stv_a, exp_v);
      check("stat_rfsh", str_a, 0);
      stat_clr = 1'b1;
      @(posedge fclk);
      #1 stat_clr = 1'b0;
      check("stat_clr", {stv_a, stc_a, str_a}, 0);

      // Refresh tick on idle bus, RFSH_DIV = 8
      reset_b();
      first = 0; second = 0;
      for (int n = 1; n <= 20; n++) begin
         @(posedge fclk); #1;
         cyc_end_b = (n == 10 || n == 18);
         if (n == 8) check("rt_pend_up", pend_b, 1);
         if (n == 9) check("rt_pend_dn", pend_b, 0);
         if (n == 17) check("rt_pend_dn2", pend_b, 0);
         if (go_b && rfsh_b) begin
            if (first == 0) first = n;
            else if (second == 0) second = n;
         end
      end
      check("rt_first_go", first, 9);
      check("rt_second_go", second, 17);
      cyc_end_b = 1'b0;

      // Tick and refresh issue on the same edge
      reset_b();
      video_req_b = 1'b1;
      for (int n = 1; n <= 16; n++) begin
         @(posedge fclk); #1;
         cyc_end_b = (n == 14);
         if (n == 1) begin
            check("sim_vid_go", {go_b, video_grant_b}, 2'b11);
            video_req_b = 1'b0;
         end
         if (n == 15) check("sim_pre", {go_b, pend_b}, 4'b0001);
         if (n == 16) begin
            check("sim_rfsh_go", {go_b, rfsh_b}, 2'b11);
            check("sim_pend_hold", pend_b, 1);
            check("sim_no_ovf", ovf_b, 0);
         end
      end

      // Forced refresh and overflow with video held and no cycle end
      reset_b();
      video_req_b = 1'b1;
      for (int n = 1; n <= 43; n++) begin
         @(posedge fclk); #1;
         cyc_end_b = (n == 41);
         if (n == 1) check("ovf_vid", {video_grant_b, rnw_b, bsel_b}, 4'b1111);
         if (n == 32) check("ovf_pend4", {ovf_b, pend_b}, 4'b0100);
         if (n == 39) check("ovf_not_yet", {ovf_b, pend_b}, 4'b0100);
         if (n == 40) check("ovf_set", {ovf_b, pend_b}, 4'b1100);
         if (n == 42) check("ovf_idle_gap", go_b, 0);
         if (n == 43) begin
            check("ovf_forced", {go_b, rfsh_b, video_grant_b}, 3'b110);
            check("ovf_pend3", {ovf_b, pend_b}, 4'b1011);
            check("ovf_addr_hold", addr_b, 21'h0ABCD);
         end
      end
      video_req_b = 1'b0;
      repeat (2) @(posedge fclk);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
